// File: rtl/usb_irq_if.sv
// ---------------------------------------------------------------------------
// usb_irq_if
//
// Purpose: Avalon-MM slave bus bundle for the usb_irq_aggregator register
//          file (16-bit data, 3-bit word address).
//
// Signals:
//   address     master -> slave   register word address
//   chipselect  master -> slave   slave select
//   write_n     master -> slave   active-low write strobe
//   writedata   master -> slave   write data
//   readdata    slave  -> master  registered read data
//
// Handshake: there are no wait states and no valid/ready pair. A write is
// accepted on every rising clk edge where chipselect=1 and write_n=0. Reads
// have a fixed latency of one cycle: readdata after an edge always holds the
// register selected by the address sampled at that edge, whether or not
// chipselect is asserted.
// ---------------------------------------------------------------------------
interface usb_irq_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/usb_irq_aggregator.sv
// ---------------------------------------------------------------------------
// usb_irq_aggregator
//
// Purpose: synchronizes up to 16 asynchronous interrupt sources, latches each
//          as a level or rising-edge event, masks them and drives a single
//          registered interrupt to the CPU. Software sees the state through a
//          small Avalon-MM register file (1-cycle read latency).
//
// Ports:
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   irq_in    raw interrupt requests, active-high, asynchronous to clk
//   bus       usb_irq_if.slave register bus
//   irq_out   aggregated interrupt, registered
//
// Register map (word addresses):
//   0 PENDING  R / W1C (edge-mode bits only)
//   1 MASK     RW, 1 = source enabled
//   2 EDGE_SEL RW, 1 = rising-edge latched, 0 = level
//   3 ACTIVE   RO, PENDING & MASK
//   4 VECTOR   RO, bit15 = any active, [3:0] = lowest active index
//   5 FORCE    WO, sets edge-mode PENDING bits, reads 0
//   6 HOLDOFF  RW holdoff reload value (only with USB_IRQ_HOLDOFF_EN)
//   7          reads 0
//
// Build option: define USB_IRQ_HOLDOFF_EN to add the HOLDOFF register and the
// down-counter that suppresses irq_out after every write to PENDING.
// ---------------------------------------------------------------------------
module usb_irq_aggregator #(
    parameter int NUM_SRC     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] irq_in,
    usb_irq_if.slave           bus,
    output logic               irq_out
);

    localparam logic [2:0] ADDR_PENDING  = 3'd0;
    localparam logic [2:0] ADDR_MASK     = 3'd1;
    localparam logic [2:0] ADDR_EDGE_SEL = 3'd2;
    localparam logic [2:0] ADDR_ACTIVE   = 3'd3;
    localparam logic [2:0] ADDR_VECTOR   = 3'd4;
    localparam logic [2:0] ADDR_FORCE    = 3'd5;
    localparam logic [2:0] ADDR_HOLDOFF  = 3'd6;

    logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
    logic [NUM_SRC-1:0] sync_d [SYNC_STAGES];
    logic [NUM_SRC-1:0] prev_q, prev_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [NUM_SRC-1:0] edge_sel_q, edge_sel_d;
    logic [15:0]        readdata_q, readdata_d;
    logic               irq_q, irq_d;

    logic [NUM_SRC-1:0] sync_val;
    logic [NUM_SRC-1:0] edge_ev;
    logic [NUM_SRC-1:0] active;
    logic [NUM_SRC-1:0] wdata;
    logic [NUM_SRC-1:0] w1c_bits;
    logic [NUM_SRC-1:0] force_bits;
    logic [3:0]         vec_idx;
    logic [15:0]        vector_w;
    logic [15:0]        pending_w, mask_w, edge_sel_w, active_w;
    logic               wr_en;
    logic               wr_pending, wr_mask, wr_edge_sel, wr_force;

    // Upper writedata bits are ignored when NUM_SRC < 16 and HOLDOFF is absent.
    logic unused_wdata;
    assign unused_wdata = ^bus.writedata;

    assign wr_en       = bus.chipselect & ~bus.write_n;
    assign wr_pending  = wr_en && (bus.address == ADDR_PENDING);
    assign wr_mask     = wr_en && (bus.address == ADDR_MASK);
    assign wr_edge_sel = wr_en && (bus.address == ADDR_EDGE_SEL);
    assign wr_force    = wr_en && (bus.address == ADDR_FORCE);
    assign wdata       = bus.writedata[NUM_SRC-1:0];

    assign sync_val = sync_q[SYNC_STAGES-1];
    assign edge_ev  = sync_val & ~prev_q;
    assign active   = pending_q & mask_q;

    always_comb begin
        sync_d[0] = irq_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_comb begin
        prev_d     = sync_val;
        mask_d     = wr_mask     ? wdata : mask_q;
        edge_sel_d = wr_edge_sel ? wdata : edge_sel_q;
        w1c_bits   = wr_pending  ? wdata : '0;
        force_bits = wr_force    ? wdata : '0;
        // Edge bits: set terms are OR'd after the clear so an event or FORCE
        // arriving with a W1C in the same cycle leaves the bit set.
        // Level bits simply follow the synchronized input.
        pending_d  = (edge_sel_q & ((pending_q & ~w1c_bits) | edge_ev | force_bits))
                   | (~edge_sel_q & sync_val);
    end

    // Lowest-numbered active source wins: scan downward so the last hit sticks.
    always_comb begin
        vec_idx = 4'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                vec_idx = 4'(i);
            end
        end
        vector_w = (|active) ? {1'b1, 11'd0, vec_idx} : 16'h0000;
    end

`ifdef USB_IRQ_HOLDOFF_EN
    logic [15:0] holdoff_q, holdoff_d;
    logic [15:0] cnt_q, cnt_d;
    logic        wr_holdoff;

    assign wr_holdoff = wr_en && (bus.address == ADDR_HOLDOFF);

    always_comb begin
        holdoff_d = wr_holdoff ? bus.writedata : holdoff_q;
        if (wr_pending) begin
            cnt_d = holdoff_q;
        end else if (cnt_q != 16'd0) begin
            cnt_d = cnt_q - 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
        // Gating on the next count makes irq_out drop on the same edge that
        // loads the counter, giving exactly HOLDOFF low cycles.
        irq_d = (|active) & (cnt_d == 16'd0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            holdoff_q <= 16'd0;
            cnt_q     <= 16'd0;
        end else begin
            holdoff_q <= holdoff_d;
            cnt_q     <= cnt_d;
        end
    end
`else
    always_comb begin
        irq_d = |active;
    end
`endif

    always_comb begin
        pending_w  = '0;
        mask_w     = '0;
        edge_sel_w = '0;
        active_w   = '0;
        pending_w[NUM_SRC-1:0]  = pending_q;
        mask_w[NUM_SRC-1:0]     = mask_q;
        edge_sel_w[NUM_SRC-1:0] = edge_sel_q;
        active_w[NUM_SRC-1:0]   = active;
        case (bus.address)
            ADDR_PENDING:  readdata_d = pending_w;
            ADDR_MASK:     readdata_d = mask_w;
            ADDR_EDGE_SEL: readdata_d = edge_sel_w;
            ADDR_ACTIVE:   readdata_d = active_w;
            ADDR_VECTOR:   readdata_d = vector_w;
`ifdef USB_IRQ_HOLDOFF_EN
            ADDR_HOLDOFF:  readdata_d = holdoff_q;
`endif
            default:       readdata_d = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q     <= '0;
            pending_q  <= '0;
            mask_q     <= '0;
            edge_sel_q <= '0;
            readdata_q <= 16'h0000;
            irq_q      <= 1'b0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            prev_q     <= prev_d;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            edge_sel_q <= edge_sel_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign irq_out      = irq_q;

endmodule

// File: tb/tb_usb_irq_aggregator.sv
// ---------------------------------------------------------------------------
// tb_usb_irq_aggregator
//
// Directed self-checking bench for usb_irq_aggregator (NUM_SRC=8,
// SYNC_STAGES=2). Expected values are pushed to exp_q as each step is driven
// and popped when the corresponding DUT output is sampled, 1 time unit after
// the clock edge. Define USB_IRQ_HOLDOFF_EN to exercise the holdoff counter.
// ---------------------------------------------------------------------------
module tb_usb_irq_aggregator;

    localparam int NUM_SRC = 8;

    localparam logic [2:0] A_PENDING  = 3'd0;
    localparam logic [2:0] A_MASK     = 3'd1;
    localparam logic [2:0] A_EDGE_SEL = 3'd2;
    localparam logic [2:0] A_ACTIVE   = 3'd3;
    localparam logic [2:0] A_VECTOR   = 3'd4;
    localparam logic [2:0] A_FORCE    = 3'd5;
    localparam logic [2:0] A_HOLDOFF  = 3'd6;
    localparam logic [2:0] A_UNUSED   = 3'd7;

    // ---------------- clock / reset ----------------
    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [NUM_SRC-1:0] irq_in;
    logic               irq_out;

    always #5 clk = ~clk;

    usb_irq_if bus_if ();

    usb_irq_aggregator #(
        .NUM_SRC     (NUM_SRC),
        .SYNC_STAGES (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .irq_in  (irq_in),
        .bus     (bus_if.slave),
        .irq_out (irq_out)
    );

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    int          n_vec  = 0;
    int          n_fail = 0;

    task automatic compare(input string tag, input logic [15:0] obs);
        logic [15:0] exp;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: observed 0x%04h but no expected value queued", tag, obs);
            return;
        end
        exp = exp_q.pop_front();
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        bus_if.address    = a;
        bus_if.writedata  = d;
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
        tick();
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string tag);
        exp_q.push_back(exp);
        bus_if.address = a;
        tick();
        compare(tag, bus_if.readdata);
    endtask

    task automatic chk_irq(input logic exp, input string tag);
        exp_q.push_back({15'd0, exp});
        compare(tag, {15'd0, irq_out});
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        irq_in            = '0;
        bus_if.address    = 3'd0;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.writedata  = 16'h0000;

        // Reset state
        #12;
        reset_n = 1'b1;
        chk_irq(1'b0, "reset_irq_out");
        exp_q.push_back(16'h0000);
        compare("reset_readdata", bus_if.readdata);
        tick();
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), 16'h0000, "reset_reg_read");
        end

        // Edge mode on source 0: 3-cycle pulse
        wr(A_EDGE_SEL, 16'h0001);
        wr(A_MASK, 16'h0001);
        irq_in[0] = 1'b1;
        tick();
        tick();
        rd(A_PENDING, 16'h0000, "edge_pending_not_yet");
        irq_in[0] = 1'b0;
        chk_irq(1'b0, "edge_irq_not_yet");
        rd(A_PENDING, 16'h0001, "edge_pending_set");
        chk_irq(1'b1, "edge_irq_set");
        wr(A_PENDING, 16'h0001);
        chk_irq(1'b1, "w1c_irq_lag");
        tick();
        chk_irq(1'b0, "w1c_irq_clear");
        rd(A_PENDING, 16'h0000, "w1c_pending_clear");

        // Level mode and priority
        wr(A_EDGE_SEL, 16'h0000);
        wr(A_MASK, 16'h00FF);
        irq_in[5] = 1'b1;
        irq_in[2] = 1'b1;
        repeat (3) tick();
        rd(A_VECTOR, 16'h8002, "vector_2_and_5");
        rd(A_ACTIVE, 16'h0024, "active_2_and_5");
        irq_in[2] = 1'b0;
        repeat (3) tick();
        rd(A_VECTOR, 16'h8005, "vector_5_only");
        irq_in[5] = 1'b0;
        repeat (3) tick();
        rd(A_VECTOR, 16'h0000, "vector_none");
        chk_irq(1'b0, "level_irq_clear");

        // Edge event and W1C in the same cycle: set wins
        wr(A_EDGE_SEL, 16'h00FF);
        irq_in[3] = 1'b1;
        tick();
        tick();
        wr(A_PENDING, 16'h0008);
        rd(A_PENDING, 16'h0008, "edge_w1c_same_cycle");
        wr(A_PENDING, 16'h0008);
        rd(A_PENDING, 16'h0000, "w1c_held_level_no_edge");
        irq_in[3] = 1'b0;

        // FORCE and MASK
        wr(A_MASK, 16'h0000);
        wr(A_FORCE, 16'h0010);
        rd(A_PENDING, 16'h0010, "force_pending");
        rd(A_ACTIVE, 16'h0000, "force_masked_active");
        chk_irq(1'b0, "force_masked_irq");
        rd(A_FORCE, 16'h0000, "force_reads_zero");
        rd(A_UNUSED, 16'h0000, "addr7_reads_zero");
        wr(A_MASK, 16'h0010);
        chk_irq(1'b0, "mask_irq_lag");
        tick();
        chk_irq(1'b1, "mask_irq_set");
        rd(A_VECTOR, 16'h8004, "vector_forced_4");
        wr(A_MASK, 16'hFF10);
        rd(A_MASK, 16'h0010, "mask_upper_bits_ignored");

        // Edge -> level on bit 4 follows the (low) input; FORCE ignored there
        wr(A_EDGE_SEL, 16'h00EF);
        tick();
        rd(A_PENDING, 16'h0000, "edge_to_level_tracks");
        wr(A_FORCE, 16'h0010);
        rd(A_PENDING, 16'h0000, "force_ignored_level");

        // Source 1 pending via FORCE
        wr(A_EDGE_SEL, 16'h0002);
        wr(A_MASK, 16'h0002);
        wr(A_FORCE, 16'h0002);
        tick();
        chk_irq(1'b1, "src1_irq_set");

`ifdef USB_IRQ_HOLDOFF_EN
        wr(A_HOLDOFF, 16'h0005);
        rd(A_HOLDOFF, 16'h0005, "holdoff_readback");
        wr(A_PENDING, 16'h0000);
        chk_irq(1'b0, "holdoff_low");
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_irq(1'b0, "holdoff_low");
        end
        tick();
        chk_irq(1'b1, "holdoff_release");
        // Start a long count that reset must abort
        wr(A_HOLDOFF, 16'd20);
        wr(A_PENDING, 16'h0000);
        tick();
        tick();
`else
        wr(A_PENDING, 16'h0000);
        chk_irq(1'b1, "pending_write_no_holdoff");
        wr(A_HOLDOFF, 16'hFFFF);
        rd(A_HOLDOFF, 16'h0000, "addr6_reads_zero");
        chk_irq(1'b1, "src1_irq_still_set");
`endif

        // Asynchronous reset mid-operation
        reset_n = 1'b0;
        #1;
        chk_irq(1'b0, "async_reset_irq");
        exp_q.push_back(16'h0000);
        compare("async_reset_readdata", bus_if.readdata);
        #3;
        reset_n = 1'b1;
        tick();
        rd(A_MASK, 16'h0000, "post_reset_mask");
        chk_irq(1'b0, "post_reset_irq");
`ifdef USB_IRQ_HOLDOFF_EN
        rd(A_HOLDOFF, 16'h0000, "post_reset_holdoff");
`endif
        wr(A_EDGE_SEL, 16'h0002);
        wr(A_MASK, 16'h0002);
        wr(A_FORCE, 16'h0002);
        tick();
        chk_irq(1'b1, "post_reset_irq_unsuppressed");

        n_vec++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d left expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
